// File: rtl/rv32_memory.sv
// rv32_memory: single-port word memory for the rv32 core with a
// byte-serial program loader that holds the core in reset while loading.
//
// Ports:
//   clk, reset        clock, async active-high reset
//   mem_addr/rd/wr    core word address, read and write requests
//   wr_data, rd_data  core write word, registered read word
//   core_reset        reset line driven into the core
//   ld_start, ld_end  load begin/end pulses
//   ld_valid, ld_byte loader byte stream, ld_ready acceptance
//   ld_words          words written in the current/last load
//   ld_overflow       sticky load-address wrap flag
module rv32_memory #(
    parameter int ADDR_BITS   = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          mem_addr,
    input  logic                 mem_rd,
    input  logic                 mem_wr,
    input  logic [31:0]          wr_data,
    output logic [31:0]          rd_data,
    output logic                 core_reset,
    input  logic                 ld_start,
    input  logic                 ld_end,
    input  logic                 ld_valid,
    input  logic [7:0]           ld_byte,
    output logic                 ld_ready,
    output logic [ADDR_BITS:0]   ld_words,
    output logic                 ld_overflow
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_BITS:0] WORDS_MAX = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS-1:0] ADDR_LAST = {ADDR_BITS{1'b1}};

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RUN,
        ST_LOAD
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  core_reset_q, core_reset_d;
    logic [31:0]           rd_data_q, rd_data_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [23:0]           buf_q, buf_d;
    logic [ADDR_BITS-1:0]  waddr_q, waddr_d;
    logic [ADDR_BITS:0]    words_q, words_d;
    logic                  ovf_q, ovf_d;

    logic [31:0]           mem_q [DEPTH];

    logic [ADDR_BITS-1:0]  caddr;
    logic                  core_en;
    logic                  ld_acc;
    logic                  ld_we;
    logic                  mem_we;
    logic [ADDR_BITS-1:0]  mem_waddr;
    logic [31:0]           mem_wdata;
    logic                  unused_addr;

    assign caddr       = mem_addr[ADDR_BITS-1:0];
    assign unused_addr = ^mem_addr[31:ADDR_BITS];

    // A core access in the cycle that starts a load is dropped, since
    // core_reset rises on that same edge.
    assign core_en = (state_q == ST_RUN) && !ld_start;
    assign ld_acc  = (state_q == ST_LOAD) && ld_valid && !ld_start;
    assign ld_we   = ld_acc && (bcnt_q == 2'd3);

    // State machine: ld_start dominates every other transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (ld_start) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                ST_LOAD: begin
                    if (ld_end) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
        core_reset_d = (state_d != ST_RUN);
    end

    // Core read path; the array read sees pre-edge contents, giving
    // read-before-write when read and write share a cycle.
    always_comb begin
        rd_data_d = rd_data_q;
        if (core_en && mem_rd) begin
            rd_data_d = mem_q[caddr];
        end
    end

    // Loader byte assembly, little-endian.
    always_comb begin
        bcnt_d  = bcnt_q;
        buf_d   = buf_q;
        waddr_d = waddr_q;
        words_d = words_q;
        ovf_d   = ovf_q;
        if (ld_start) begin
            bcnt_d  = '0;
            waddr_d = '0;
            words_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (ld_acc) begin
                case (bcnt_q)
                    2'd0: buf_d[7:0]   = ld_byte;
                    2'd1: buf_d[15:8]  = ld_byte;
                    2'd2: buf_d[23:16] = ld_byte;
                    default: buf_d     = buf_q;
                endcase
                if (ld_we) begin
                    bcnt_d  = '0;
                    waddr_d = waddr_q + 1'b1;
                    if (words_q != WORDS_MAX) begin
                        words_d = words_q + 1'b1;
                    end
                    if (waddr_q == ADDR_LAST) begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            // A partial word left at ld_end is dropped.
            if ((state_q == ST_LOAD) && ld_end) begin
                bcnt_d = '0;
            end
        end
    end

    // Single write port shared by core and loader; they are never
    // active in the same state.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = caddr;
        mem_wdata = wr_data;
        if (ld_we) begin
            mem_we    = 1'b1;
            mem_waddr = waddr_q;
            mem_wdata = {ld_byte, buf_q};
        end else if (core_en && mem_wr) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_HOLD;
            cnt_q        <= '0;
            core_reset_q <= 1'b1;
            rd_data_q    <= '0;
            bcnt_q       <= '0;
            buf_q        <= '0;
            waddr_q      <= '0;
            words_q      <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            core_reset_q <= core_reset_d;
            rd_data_q    <= rd_data_d;
            bcnt_q       <= bcnt_d;
            buf_q        <= buf_d;
            waddr_q      <= waddr_d;
            words_q      <= words_d;
            ovf_q        <= ovf_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign core_reset  = core_reset_q;
    assign ld_ready    = (state_q == ST_LOAD);
    assign ld_words    = words_q;
    assign ld_overflow = ovf_q;

endmodule

// File: tb/tb_rv32_memory.sv
// tb_rv32_memory: randomized self-checking bench for rv32_memory,
// compared against an array model of memory and loader behaviour.
module tb_rv32_memory;

    localparam int DEPTH = 256;

    typedef logic [7:0] bytes_t [$];

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        core_reset;
    logic        ld_start;
    logic        ld_end;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_ready;
    logic [8:0]  ld_words;
    logic        ld_overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_rd;

    rv32_memory #(.ADDR_BITS(8), .HOLD_CYCLES(2)) dut (
        .clk(clk),
        .reset(reset),
        .mem_addr(mem_addr),
        .mem_rd(mem_rd),
        .mem_wr(mem_wr),
        .wr_data(wr_data),
        .rd_data(rd_data),
        .core_reset(core_reset),
        .ld_start(ld_start),
        .ld_end(ld_end),
        .ld_valid(ld_valid),
        .ld_byte(ld_byte),
        .ld_ready(ld_ready),
        .ld_words(ld_words),
        .ld_overflow(ld_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_write(input logic [31:0] addr, input logic [31:0] d);
        mem_addr = addr;
        wr_data  = d;
        mem_wr   = 1'b1;
        tick();
        mem_wr = 1'b0;
        ref_mem[addr % DEPTH] = d;
    endtask

    task automatic core_read(input string tag, input logic [31:0] addr);
        mem_addr = addr;
        mem_rd   = 1'b1;
        tick();
        mem_rd = 1'b0;
        exp_rd = ref_mem[addr % DEPTH];
        check(tag, rd_data, exp_rd);
    endtask

    // Whole-load model: word k of the stream lands at k mod DEPTH.
    task automatic do_load(input string tag, input bytes_t data,
                           input bit gaps);
        int nw;
        int ew;
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check({tag, " start core_reset"}, 32'(core_reset), 32'd1);
        check({tag, " start ld_ready"}, 32'(ld_ready), 32'd1);
        foreach (data[i]) begin
            if (gaps && ($urandom_range(3) == 0)) begin
                ld_valid = 1'b0;
                tick();
            end
            ld_valid = 1'b1;
            ld_byte  = data[i];
            tick();
        end
        ld_valid = 1'b0;
        ld_end   = 1'b1;
        tick();
        ld_end = 1'b0;
        nw = data.size() / 4;
        for (int k = 0; k < nw; k++) begin
            ref_mem[k % DEPTH] = {data[4*k+3], data[4*k+2],
                                  data[4*k+1], data[4*k]};
        end
        ew = (nw > DEPTH) ? DEPTH : nw;
        check({tag, " ld_words"}, 32'(ld_words), 32'(ew));
        check({tag, " ld_overflow"}, 32'(ld_overflow),
              32'(nw >= DEPTH));
        check({tag, " end ld_ready"}, 32'(ld_ready), 32'd0);
        check({tag, " hold0"}, 32'(core_reset), 32'd1);
        tick();
        check({tag, " hold1"}, 32'(core_reset), 32'd1);
        tick();
        check({tag, " run"}, 32'(core_reset), 32'd0);
        check({tag, " rd held"}, rd_data, exp_rd);
    endtask

    initial begin
        bytes_t      img;
        logic [31:0] a;
        logic [31:0] d;
        int          op;

        reset    = 1'b1;
        mem_addr = '0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        wr_data  = '0;
        ld_start = 1'b0;
        ld_end   = 1'b0;
        ld_valid = 1'b0;
        ld_byte  = '0;
        exp_rd   = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 'x;

        #12;
        check("rst rd_data", rd_data, 32'd0);
        check("rst core_reset", 32'(core_reset), 32'd1);
        check("rst ld_ready", 32'(ld_ready), 32'd0);
        check("rst ld_words", 32'(ld_words), 32'd0);
        check("rst ld_overflow", 32'(ld_overflow), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        check("hold e1", 32'(core_reset), 32'd1);
        check("hold e1 ld_ready", 32'(ld_ready), 32'd0);
        tick();
        check("hold e2", 32'(core_reset), 32'd0);
        check("idle rd_data", rd_data, 32'd0);
        check("idle ld_ready", 32'(ld_ready), 32'd0);

        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h80, 8'h20, 8'h00};
        do_load("prog", img, 1'b0);
        core_read("prog w0", 32'd0);
        check("prog w0 val", rd_data, 32'h0000_0013);
        core_read("prog w1", 32'd1);
        check("prog w1 val", rd_data, 32'h0020_80B3);

        core_write(32'h105, 32'hDEAD_BEEF);
        core_read("alias rd5", 32'd5);
        check("alias val", rd_data, 32'hDEAD_BEEF);
        core_write(32'd7, 32'd1);
        mem_addr = 32'd7;
        wr_data  = 32'hA5A5_5A5A;
        mem_rd   = 1'b1;
        mem_wr   = 1'b1;
        tick();
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        check("rbw old", rd_data, 32'd1);
        exp_rd = 32'd1;
        ref_mem[7] = 32'hA5A5_5A5A;
        tick();
        check("rbw hold", rd_data, exp_rd);
        core_read("rbw new", 32'd7);

        img = {};
        for (int i = 0; i < 257 * 4; i++) img.push_back(8'($urandom));
        do_load("ovf", img, 1'b1);
        core_read("ovf w0", 32'd0);
        core_read("ovf w1", 32'd1);
        core_read("ovf w255", 32'd255);

        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(3);
            a  = $urandom;
            d  = $urandom;
            mem_addr = a;
            wr_data  = d;
            mem_rd   = (op == 1) || (op == 3);
            mem_wr   = (op == 2) || (op == 3);
            tick();
            if (mem_rd) exp_rd = ref_mem[a % DEPTH];
            if (mem_wr) ref_mem[a % DEPTH] = d;
            mem_rd = 1'b0;
            mem_wr = 1'b0;
            check("rand rd_data", rd_data, exp_rd);
        end

        img = {};
        for (int i = 0; i < 7; i++) img.push_back(8'($urandom));
        do_load("part", img, 1'b0);
        core_read("part w0", 32'd0);
        core_read("part w1", 32'd1);

        ld_start = 1'b1;
        ld_end   = 1'b1;
        mem_addr = 32'd3;
        wr_data  = 32'h1234_5678;
        mem_wr   = 1'b1;
        tick();
        ld_start = 1'b0;
        ld_end   = 1'b0;
        mem_wr   = 1'b0;
        check("both ld_ready", 32'(ld_ready), 32'd1);
        check("both core_reset", 32'(core_reset), 32'd1);
        check("both ld_words", 32'(ld_words), 32'd0);
        tick();
        check("both stay", 32'(ld_ready), 32'd1);
        ld_end = 1'b1;
        tick();
        ld_end = 1'b0;
        tick();
        tick();
        check("both run", 32'(core_reset), 32'd0);
        core_read("dropped wr", 32'd3);

        img = {};
        for (int i = 0; i < 9; i++) img.push_back(8'($urandom));
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        foreach (img[i]) begin
            ld_valid = 1'b1;
            ld_byte  = img[i];
            tick();
        end
        check("mid ld_words", 32'(ld_words), 32'd2);
        ld_byte = 8'($urandom);
        #2;
        reset = 1'b1;
        #1;
        check("mid core_reset", 32'(core_reset), 32'd1);
        check("mid ld_ready", 32'(ld_ready), 32'd0);
        check("mid ld_words rst", 32'(ld_words), 32'd0);
        check("mid rd_data rst", rd_data, 32'd0);
        ld_valid = 1'b0;
        #1;
        reset = 1'b0;
        exp_rd = '0;
        for (int k = 0; k < 2; k++) begin
            ref_mem[k] = {img[4*k+3], img[4*k+2], img[4*k+1], img[4*k]};
        end
        tick();
        check("mid hold", 32'(core_reset), 32'd1);
        tick();
        check("mid run", 32'(core_reset), 32'd0);
        core_read("mid w0", 32'd0);
        core_read("mid w1", 32'd1);
        core_read("mid w2", 32'd2);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
